// File: rtl/md5_multi_control.sv
// md5_multi_control: Avalon-MM slave that controls up to 32 MD5 cores.
//   Per-unit one-cycle start/reset pulses, busy tracking, sticky W1C done
//   flags and a maskable level interrupt.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   avs_*                 Avalon-MM slave (3-bit word address, 32-bit data,
//                         fixed read latency 1)
//   md5_start/md5_reset   per-unit registered pulses
//   md5_done              per-unit level done from cores (clk domain)
//   irq                   |(DONE_STICKY & IRQ_MASK), registered
// Optional: define MD5CTRL_ACTIVE_COUNT_EN to add the saturating
//   ACTIVE_CYCLES counter at address 7 (reads 0 otherwise).

// Per-unit slot: pulse registers, busy bit and sticky done flag.
module md5_multi_control_unit (
  input  logic clk,
  input  logic reset,
  input  logic start_req,
  input  logic reset_req,
  input  logic clear_req,
  input  logic done,
  output logic start_pulse,
  output logic reset_pulse,
  output logic busy,
  output logic sticky
);
  logic done_q, rise, start_eff;

  assign rise      = done & ~done_q;
  // a busy unit ignores start; the top flags the collision
  assign start_eff = start_req & ~busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_pulse <= 1'b0;
      reset_pulse <= 1'b0;
      done_q      <= 1'b0;
      busy        <= 1'b0;
      sticky      <= 1'b0;
    end else begin
      start_pulse <= start_eff;
      reset_pulse <= reset_req;
      done_q      <= done;
      // reset pulse dominates; a start only lands on an idle unit
      busy        <= ~reset_req & ((busy & ~rise) | start_eff);
      // a new done edge wins over any clear in the same cycle
      sticky      <= rise | (sticky & ~clear_req & ~reset_req);
    end
  end
endmodule

module md5_multi_control #(
  parameter int          NUM_UNITS = 32,
  parameter logic [7:0]  ID_VALUE  = 8'h5D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [NUM_UNITS-1:0] md5_start,
  output logic [NUM_UNITS-1:0] md5_reset,
  input  logic [NUM_UNITS-1:0] md5_done,
  output logic                 irq
);
  logic [NUM_UNITS-1:0] busy, sticky, mask, wbits;
  logic                 wr_reset, wr_start, wr_sticky, wr_mask, wr_status;
  logic                 collision, rd_acc;
  logic [31:0]          rd_mux;

  assign wbits     = avs_writedata[NUM_UNITS-1:0];
  assign wr_reset  = avs_write && (avs_address == 3'd0);
  assign wr_start  = avs_write && (avs_address == 3'd1);
  assign wr_sticky = avs_write && (avs_address == 3'd3);
  assign wr_mask   = avs_write && (avs_address == 3'd5);
  assign wr_status = avs_write && (avs_address == 3'd6);
  assign rd_acc    = avs_read && !avs_write;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    md5_multi_control_unit u_unit (
      .clk        (clk),
      .reset      (reset),
      .start_req  (wr_start  & wbits[g]),
      .reset_req  (wr_reset  & wbits[g]),
      .clear_req  (wr_sticky & wbits[g]),
      .done       (md5_done[g]),
      .start_pulse(md5_start[g]),
      .reset_pulse(md5_reset[g]),
      .busy       (busy[g]),
      .sticky     (sticky[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask      <= '0;
      collision <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_mask) mask <= wbits;
      if (wr_start && |(wbits & busy))         collision <= 1'b1;
      else if (wr_status && avs_writedata[0])  collision <= 1'b0;
      irq <= |(sticky & mask);
    end
  end

`ifdef MD5CTRL_ACTIVE_COUNT_EN
  logic [31:0] active_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       active_cnt <= '0;
    else if (avs_write && avs_address == 3'd7)       active_cnt <= '0;
    else if (|busy && active_cnt != 32'hFFFF_FFFF)   active_cnt <= active_cnt + 32'd1;
  end
`endif

  // read mux sees pre-update state; unit vectors zero-extend to 32 bits
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd2: rd_mux[NUM_UNITS-1:0] = md5_done;
      3'd3: rd_mux[NUM_UNITS-1:0] = sticky;
      3'd4: rd_mux[NUM_UNITS-1:0] = busy;
      3'd5: rd_mux[NUM_UNITS-1:0] = mask;
      3'd6: rd_mux = {10'd0, 6'(NUM_UNITS), ID_VALUE, 7'd0, collision};
`ifdef MD5CTRL_ACTIVE_COUNT_EN
      3'd7: rd_mux = active_cnt;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_acc;
      if (rd_acc) avs_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_md5_multi_control.sv
// Randomized + directed bench for md5_multi_control. A behavioural model
// tracks the register file per unit; reads push expected data into a queue
// that a negedge monitor pops whenever readdatavalid is seen.
module tb_md5_multi_control;
  localparam int NU = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic [NU-1:0] md5_start, md5_reset, md5_done = '0;
  logic          irq;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  md5_multi_control #(.NUM_UNITS(NU), .ID_VALUE(8'h5D)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .md5_start(md5_start), .md5_reset(md5_reset), .md5_done(md5_done), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NU-1:0] m_busy, m_sticky, m_mask, m_doneq, exp_start, exp_rst;
  logic          m_coll, m_irq;
  logic [31:0]   m_cnt;
  logic [31:0]   rdq[$];

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd2: return 32'(md5_done);
      3'd3: return 32'(m_sticky);
      3'd4: return 32'(m_busy);
      3'd5: return 32'(m_mask);
      3'd6: return {10'd0, 6'd8, 8'h5D, 7'd0, m_coll};
`ifdef MD5CTRL_ACTIVE_COUNT_EN
      3'd7: return m_cnt;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = '0; m_sticky = '0; m_mask = '0; m_doneq = '0;
      exp_start = '0; exp_rst = '0; m_coll = 0; m_irq = 0; m_cnt = 0;
      rdq.delete();
    end else begin
      logic coll_set, coll_clr, rise;
      logic [NU-1:0] clr;
      coll_set = 0; coll_clr = 0; clr = '0;
      if (avs_read && !avs_write) rdq.push_back(model_read(avs_address));
      m_irq = |(m_sticky & m_mask);
      if (avs_write && avs_address == 3'd7) m_cnt = 0;
      else if (m_busy != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      exp_start = '0; exp_rst = '0;
      if (avs_write) begin
        case (avs_address)
          3'd0: exp_rst = avs_writedata[NU-1:0];
          3'd1: for (int i = 0; i < NU; i++)
                  if (avs_writedata[i]) begin
                    if (m_busy[i]) coll_set = 1; else exp_start[i] = 1;
                  end
          3'd3: clr = avs_writedata[NU-1:0];
          3'd5: m_mask = avs_writedata[NU-1:0];
          3'd6: coll_clr = avs_writedata[0];
          default: ;
        endcase
      end
      for (int i = 0; i < NU; i++) begin
        rise = md5_done[i] && !m_doneq[i];
        if (exp_rst[i])        m_busy[i] = 0;
        else if (exp_start[i]) m_busy[i] = 1;
        else if (rise)         m_busy[i] = 0;
        if (rise)                      m_sticky[i] = 1;
        else if (clr[i] || exp_rst[i]) m_sticky[i] = 0;
      end
      m_doneq = md5_done;
      if (coll_set) m_coll = 1; else if (coll_clr) m_coll = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("start_pulse", 32'(md5_start), 32'(exp_start));
    chk("reset_pulse", 32'(md5_reset), 32'(exp_rst));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rd_valid", 32'(avs_readdatavalid), 32'(rdq.size() > 0));
    if (rdq.size() > 0) begin
      logic [31:0] e;
      e = rdq.pop_front();
      if (avs_readdatavalid) chk("readdata", avs_readdata, e);
    end
  end

  // ---------------- driver ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    @(negedge clk);
    avs_write = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    avs_address = a; avs_read = 1;
    @(negedge clk);
    avs_read = 0;
    q = avs_readdata;
  endtask

  initial begin
    logic [31:0] q;
    repeat (3) @(negedge clk);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 0;
    repeat (6) @(negedge clk);

    // start units 0 and 2
    wr(3'd1, 32'h5);
    chk("start5", 32'(md5_start), 32'h5);
    @(negedge clk);
    chk("start5_once", 32'(md5_start), 32'h0);
    rd(3'd4, q); chk("busy5", q, 32'h5);
    rd(3'd6, q); chk("status", q, 32'h0008_5D00);

    // collision
    wr(3'd1, 32'h7);
    chk("start_gated", 32'(md5_start), 32'h2);
    rd(3'd6, q); chk("coll_set", q, 32'h0008_5D01);
    wr(3'd6, 32'h1);
    rd(3'd6, q); chk("coll_clr", q, 32'h0008_5D00);

    // done on unit 2, irq path
    wr(3'd5, 32'h4);
    md5_done[2] = 1;
    repeat (5) @(negedge clk);
    rd(3'd3, q); chk("sticky4", q, 32'h4);
    rd(3'd4, q); chk("busy3", q, 32'h3);
    chk("irq_on", 32'(irq), 32'd1);
    wr(3'd3, 32'h4);
    chk("irq_lag", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_off", 32'(irq), 32'd0);
    rd(3'd3, q); chk("sticky_no_reset", q, 32'h0);
    md5_done[2] = 0;

    // W1C coinciding with a done edge: set wins
    md5_done[0] = 1;
    wr(3'd3, 32'h1);
    rd(3'd3, q); chk("set_wins", q, 32'h1);

    // reset pulse on busy unit with sticky set
    md5_done[0] = 0;
    @(negedge clk);
    wr(3'd1, 32'h1);
    chk("restart0", 32'(md5_start), 32'h1);
    wr(3'd0, 32'h1);
    chk("rst0_pulse", 32'(md5_reset), 32'h1);
    @(negedge clk);
    chk("rst0_once", 32'(md5_reset), 32'h0);
    rd(3'd4, q); chk("busy_after_rst", q, 32'h2);
    rd(3'd3, q); chk("sticky_after_rst", q, 32'h0);

    // bits at NUM_UNITS and above
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, q); chk("mask_width", q, 32'hFF);
    wr(3'd1, 32'hFFFF_FF00);
    chk("start_hi_bits", 32'(md5_start), 32'h0);

    // active counter
    wr(3'd0, 32'hFF);
    wr(3'd7, 32'h0);
    wr(3'd1, 32'h8);
    repeat (100) @(negedge clk);
    rd(3'd7, q);
`ifdef MD5CTRL_ACTIVE_COUNT_EN
    chk("cnt_range", 32'(q >= 32'd98 && q <= 32'd102), 32'd1);
`else
    chk("cnt_absent", q, 32'd0);
`endif
    wr(3'd0, 32'h8);
    wr(3'd7, 32'h0);
    rd(3'd7, q); chk("cnt_cleared", q, 32'd0);

    // async reset mid-operation
    wr(3'd5, 32'hFF);
    md5_done[1] = 1;
    repeat (3) @(negedge clk);
    chk("irq_pre", 32'(irq), 32'd1);
    rd(3'd6, q);
    wr(3'd1, 32'h4);
    chk("start_pre", 32'(md5_start), 32'h4);
    #2 reset = 1;
    #1;
    chk("async_start", 32'(md5_start), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_rdata", avs_readdata, 32'd0);
    md5_done = '0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      avs_address = 3'($urandom_range(0, 7));
      avs_writedata = $urandom & $urandom;
      avs_read  = (r < 3) || (r == 6);
      avs_write = (r >= 3 && r <= 6);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, NU - 1);
        md5_done[k] = ~md5_done[k];
      end
      @(negedge clk);
    end
    avs_read = 0; avs_write = 0;
    repeat (3) @(negedge clk);
    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_multi_control.md
Name: md5_multi_control

Overview:
- Avalon-MM slave that controls up to 32 MD5 hash cores.
- Generates one-cycle start/reset pulses per unit and tracks per-unit busy state.
- Latches done events into sticky write-1-to-clear flags and raises a maskable interrupt.
- Sits between the HPS/Nios bus and the md5 core array; generalises the single-bank control register with channel-count parametrisation, busy tracking and an interrupt.

Parameters:
- NUM_UNITS, 32, number of md5 cores controlled (1..32); register bits at index NUM_UNITS and above read 0 and ignore writes.
- ID_VALUE, 8'h5D, constant returned in STATUS[15:8].

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- avs_address  input  3  word address
- avs_read  input  1  read strobe
- avs_write  input  1  write strobe
- avs_writedata  input  32  write data
- avs_readdata  output  32  read data, registered
- avs_readdatavalid  output  1  high for the one cycle after an accepted read
- md5_start  output  NUM_UNITS  per-unit start pulse
- md5_reset  output  NUM_UNITS  per-unit reset pulse
- md5_done  input  NUM_UNITS  per-unit level done from cores (synchronous to clk)
- irq  output  1  level interrupt

Behaviour:
- Reset is asynchronous. While reset is asserted, all of the following are 0: outputs, pulses, busy, sticky, mask, collision flag, done_q and the counter.
- Register map (word address):
  - 0 RESET (W): pulse md5_reset. Reads return 0.
  - 1 START (W): pulse md5_start. Reads return 0.
  - 2 DONE_RAW (R): live md5_done.
  - 3 DONE_STICKY (R/W1C).
  - 4 BUSY (R).
  - 5 IRQ_MASK (R/W).
  - 6 STATUS: bit0 start_collision (W1C), [15:8] ID_VALUE, [21:16] NUM_UNITS.
  - 7 ACTIVE_CYCLES (see Optional Feature).
- Pulses:
  - A write in cycle N drives the pulse outputs in cycle N+1 for exactly one cycle; they are 0 in all other cycles.
  - Pulses are registered only (no combinational path from the bus).
- START gating:
  - The effective start bits are wdata & ~busy.
  - If any requested bit hits a busy unit, that bit is not pulsed and start_collision is set.
- BUSY:
  - A bit is set when its start pulse is issued.
  - A bit is cleared on a done rising edge or when a reset pulse is issued for that bit.
  - Reset pulse wins over start in the same cycle. This cannot occur from one write, but the rule also applies to back-to-back writes.
- DONE_STICKY:
  - done_q is md5_done registered one cycle. Bit i sets when md5_done[i] & ~done_q[i].
  - A W1C write clears the written bits; if a set and a clear coincide in one cycle, set wins.
  - Issuing a reset pulse to unit i clears sticky bit i.
- irq is registered: irq = |(DONE_STICKY & IRQ_MASK), updated one cycle after any change.
- Reads:
  - Accepted when avs_read=1 and avs_write=0.
  - avs_readdata is loaded at the next edge; avs_readdatavalid is high that cycle.
  - Fixed latency 1, back-to-back reads allowed.
  - Read data reflects register state before any same-cycle update.
  - avs_readdata holds its value when no read is accepted.
- Simultaneous read and write: the write is performed and the read is ignored (no readdatavalid).
- Reads have no side effects.

Optional Feature:
- Macro MD5CTRL_ACTIVE_COUNT_EN.
- When defined:
  - A 32-bit counter increments every cycle in which BUSY is nonzero and saturates at 32'hFFFFFFFF.
  - Address 7 reads the counter; any write to address 7 clears it to 0. A clear wins over an increment in the same cycle.
- When undefined: address 7 reads 0, writes are ignored, and no counter logic is present.

Test Plan:
- Write START=32'h0000_0005 at cycle 10 → md5_start=5 in cycle 11 only. BUSY reads 5; start_collision=0.
- Units 0,2 busy, then write START=32'h0000_0007 → only md5_start=2 is pulsed, start_collision=1. Writing STATUS=1 clears start_collision.
- Raise md5_done[2] and hold it high for 5 cycles → DONE_STICKY bit2 set once and BUSY bit2 cleared. With IRQ_MASK=4, irq=1; W1C of 4 drops irq one cycle later, with no re-set while done stays high.
- In the same cycle as a W1C of bit0, a done rising edge occurs on unit 0 → sticky bit0 remains 1.
- Write RESET=32'h1 while unit 0 is busy with sticky set → md5_reset[0] pulses one cycle; BUSY bit0=0 and sticky bit0=0. Asserting async reset mid-operation clears all outputs immediately, without a clock edge.
- With the macro defined: start a unit, wait 100 cycles, read address 7 → value in 100±2. Write address 7, then read → 0 while idle. With the macro undefined: read returns 0.
